// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO sequencing stage between EX and the dmu multiply/divide unit
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, registers dmu operands, holds dmu_en for a
// fixed latency, then captures dmu_hi/dmu_lo into the architectural HI/LO registers.
// Optional feature macro: HILO_DIVZERO_CHK_EN (skip DIV/DIVU with a zero divisor).
//
// Ports:
//   clk, rstn              clock (rising edge), asynchronous active-low reset
//   req_valid/op/a/b       EX-stage HI/LO request (rs = req_a, rt = req_b)
//   req_ready              high only while IDLE
//   flush                  synchronous abort of an accepted/in-flight op
//   rd_en, rd_sel, rd_data MFHI/MFLO read port (rd_sel 1 = HI), combinational
//   stall                  pipeline hold for dependent HI/LO access during RUN
//   dmu_en/m/a/b           registered controls and operands to dmu
//   dmu_hi, dmu_lo         dmu results
//   hi, lo                 architectural HI/LO
module hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 36
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             req_ready,
    input  logic             flush,
    input  logic             rd_en,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             dmu_en,
    output logic [3:0]       dmu_m,
    output logic [WIDTH-1:0] dmu_a,
    output logic [WIDTH-1:0] dmu_b,
    input  logic [WIDTH-1:0] dmu_hi,
    input  logic [WIDTH-1:0] dmu_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic accept;
    logic is_div;
    logic div_zero;
    logic start;

    // Ops 000..011 go to dmu; bit 1 selects divide, bit 0 selects unsigned.
    assign accept = (state == IDLE) && req_valid && !flush;
    assign is_div = req_op[1];

`ifdef HILO_DIVZERO_CHK_EN
    assign div_zero = is_div && (req_b == '0);
`else
    assign div_zero = 1'b0;
`endif

    assign start = accept && !req_op[2] && !div_zero;

    assign req_ready = (state == IDLE);
    assign stall     = (state == RUN) && (rd_en || req_valid);
    assign rd_data   = rd_sel ? hi : lo;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            dmu_en <= 1'b0;
            dmu_m  <= 4'b0000;
            dmu_a  <= '0;
            dmu_b  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // dmu takes the divisor on port a, so rs/rt are swapped.
                        dmu_a  <= req_b;
                        dmu_b  <= req_a;
                        dmu_m  <= {req_op[0], 2'b00, req_op[1]};
                        cnt    <= is_div ? DIV_CNT : MUL_CNT;
                        dmu_en <= 1'b1;
                        state  <= RUN;
                    end else if (accept && req_op == 3'b100) begin
                        hi <= req_a;
                    end else if (accept && req_op == 3'b101) begin
                        lo <= req_a;
                    end
                end
                RUN: begin
                    if (flush) begin
                        cnt    <= '0;
                        dmu_en <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == '0) begin
                        hi     <= dmu_hi;
                        lo     <= dmu_lo;
                        dmu_en <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    dmu_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit with a behavioural dmu
module tb_hilo_unit;

    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic         req_valid;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_ready;
    logic         flush;
    logic         rd_en;
    logic         rd_sel;
    logic [W-1:0] rd_data;
    logic         stall;
    logic         dmu_en;
    logic [3:0]   dmu_m;
    logic [W-1:0] dmu_a;
    logic [W-1:0] dmu_b;
    logic [W-1:0] dmu_hi;
    logic [W-1:0] dmu_lo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    hilo_unit #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(36)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .flush(flush),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall),
        .dmu_en(dmu_en), .dmu_m(dmu_m), .dmu_a(dmu_a), .dmu_b(dmu_b),
        .dmu_hi(dmu_hi), .dmu_lo(dmu_lo), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmu: divisor on a, dividend on b; quotient to lo, remainder to hi.
    // Divide by zero returns lo = all ones, hi = dividend.
    logic [63:0] prod;
    always_comb begin
        prod   = '0;
        dmu_hi = '0;
        dmu_lo = '0;
        case (dmu_m)
            4'b0000: prod = 64'($signed(dmu_a) * $signed(dmu_b));
            4'b1000: prod = {32'd0, dmu_a} * {32'd0, dmu_b};
            default: prod = '0;
        endcase
        if (dmu_m[0]) begin
            if (dmu_a == '0) begin
                dmu_lo = '1;
                dmu_hi = dmu_b;
            end else if (dmu_m[3]) begin
                dmu_lo = dmu_b / dmu_a;
                dmu_hi = dmu_b % dmu_a;
            end else begin
                dmu_lo = W'($signed(dmu_b) / $signed(dmu_a));
                dmu_hi = W'($signed(dmu_b) % $signed(dmu_a));
            end
        end else begin
            dmu_hi = prod[63:32];
            dmu_lo = prod[31:0];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a request for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts cycles with dmu_en high, starting from the current one.
    task automatic wait_done(output int n);
        n = 0;
        while (dmu_en && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_a = '0; req_b = '0;
        flush = 1'b0; rd_en = 1'b0; rd_sel = 1'b0;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dmu_en", dmu_en, 0);
        check("rst_dmu_m", dmu_m, 0);
        check("rst_dmu_ab", {dmu_a, dmu_b}, 0);
        check("rst_ready", req_ready, 1);
        check("rst_stall", stall, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // MULT -3 * 7
        issue(3'b000, 32'hFFFF_FFFD, 32'd7);
        check("mult_en", dmu_en, 1);
        check("mult_m", dmu_m, 4'b0000);
        check("mult_a", dmu_a, 32'd7);
        check("mult_b", dmu_b, 32'hFFFF_FFFD);
        check("mult_ready", req_ready, 0);
        rd_en = 1'b1; rd_sel = 1'b1;
        #1;
        check("mult_stall_rd", stall, 1);
        rd_en = 1'b0;
        #1;
        check("mult_no_stall", stall, 0);
        wait_done(n);
        check("mult_lat", n, 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_ready_after", req_ready, 1);

        // DIVU 100 / 7
        issue(3'b011, 32'd100, 32'd7);
        check("divu_a", dmu_a, 32'd7);
        check("divu_b", dmu_b, 32'd100);
        check("divu_m", dmu_m, 4'b1001);
        req_valid = 1'b1; req_op = 3'b110;
        #1;
        check("divu_stall_req", stall, 1);
        req_valid = 1'b0;
        wait_done(n);
        check("divu_lat", n, 36);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // MTHI then MFHI
        issue(3'b100, 32'hDEAD_BEEF, 32'd0);
        rd_en = 1'b1; rd_sel = 1'b1;
        #1;
        check("mthi_rd", rd_data, 32'hDEAD_BEEF);
        check("mthi_lo_keep", lo, 32'd14);
        check("mthi_no_en", dmu_en, 0);
        rd_en = 1'b0;

        // MTLO then MFLO
        issue(3'b101, 32'h1234_5678, 32'd0);
        rd_en = 1'b1; rd_sel = 1'b0;
        #1;
        check("mtlo_rd", rd_data, 32'h1234_5678);
        check("mtlo_hi_keep", hi, 32'hDEAD_BEEF);
        rd_en = 1'b0;

        // Reserved op leaves everything alone
        issue(3'b111, 32'h5555_5555, 32'd3);
        check("rsvd_en", dmu_en, 0);
        check("rsvd_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        issue(3'b000, 32'd3, 32'd5);
        flush = 1'b0;
        check("flush_idle_en", dmu_en, 0);
        check("flush_idle_ready", req_ready, 1);

        // MULT flushed in RUN cycle 3
        issue(3'b000, 32'd3, 32'd5);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_en", dmu_en, 0);
        check("flush_run_ready", req_ready, 1);
        check("flush_run_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});

        // MULTU after flush: dmu_en was low this cycle, rises after the accept edge
        issue(3'b001, 32'hFFFF_FFFF, 32'd2);
        check("multu_m", dmu_m, 4'b1000);
        wait_done(n);
        check("multu_lat", n, 5);
        check("multu_hilo", {hi, lo}, {32'd1, 32'hFFFF_FFFE});

        // Signed DIV -7 / 2
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        check("div_m", dmu_m, 4'b0001);
        wait_done(n);
        check("div_lat", n, 36);
        check("div_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // DIV by zero
        issue(3'b010, 32'd50, 32'd0);
`ifdef HILO_DIVZERO_CHK_EN
        check("div0_en", dmu_en, 0);
        check("div0_ready", req_ready, 1);
        check("div0_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
        check("div0_en", dmu_en, 1);
        wait_done(n);
        check("div0_lat", n, 36);
        check("div0_hilo", {hi, lo}, {32'd50, 32'hFFFF_FFFF});
`endif

        // Asynchronous reset in RUN cycle 10 of a DIV
        issue(3'b010, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("arst_pre_en", dmu_en, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_en", dmu_en, 0);
        check("arst_m", dmu_m, 0);
        check("arst_ab", {dmu_a, dmu_b}, 0);
        check("arst_hilo", {hi, lo}, 0);
        check("arst_ready", req_ready, 1);
        check("arst_stall", stall, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("arst_rel_ready", req_ready, 1);
        check("arst_rel_en", dmu_en, 0);
        check("arst_rel_hilo", {hi, lo}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequencing and architectural-state stage for the multiply/divide path. Sits between the EX stage and the `dmu` multiply/divide unit. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests, registers operands and holds `dmu` enabled for a fixed latency, then captures its hi/lo outputs into the architectural HI/LO registers. Serves MFHI/MFLO reads and stalls the pipeline when a dependent HI/LO access arrives while an operation is in flight.

## Interface
- `WIDTH`, 32: data width.
- `MUL_LAT`, 5: cycles in RUN for MULT/MULTU before capture.
- `DIV_LAT`, 36: cycles in RUN for DIV/DIVU before capture.
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  EX-stage HI/LO op present.
- `req_op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- `req_a`  in  WIDTH  rs (multiplicand / dividend / MTHI-MTLO source).
- `req_b`  in  WIDTH  rt (multiplier / divisor).
- `req_ready`  out  1  high only in IDLE.
- `flush`  in  1  synchronous abort (exception/redirect).
- `rd_en`  in  1  MFHI/MFLO in EX.
- `rd_sel`  in  1  1 = HI, 0 = LO.
- `rd_data`  out  WIDTH  selected register value, combinational.
- `stall`  out  1  hold pipeline.
- `dmu_en`  out  1  enable to `dmu`, registered.
- `dmu_m`  out  4  `dmu` opcode: 0000 mult, 1000 umult, 0001 div, 1001 udiv.
- `dmu_a`, `dmu_b`  out  WIDTH  `dmu` operands, registered, held stable through RUN.
- `dmu_hi`, `dmu_lo`  in  WIDTH  `dmu` results.
- `hi`, `lo`  out  WIDTH  architectural HI/LO.

## Operation
- FSM states: IDLE, RUN. Down-counter `cnt` is `$clog2(DIV_LAT+1)` bits wide.
- IDLE, `req_valid & ~flush`:
  - MUL/DIV op: latch `dmu_a=req_b` and `dmu_b=req_a`, because the `dmu` divisor is port a. Set `dmu_m` per op. Load `cnt` with LAT-1, set `dmu_en=1`, go to RUN.
  - MTHI/MTLO: write `req_a` to `hi`/`lo` at the edge and stay in IDLE.
  - Reserved op: no effect.
- RUN: `dmu_en` stays 1 and `cnt` decrements each cycle. In the cycle where `cnt==0`, the next edge captures `hi<=dmu_hi`, `lo<=dmu_lo`, clears `dmu_en` and returns to IDLE.
- `flush` in RUN: the next edge goes to IDLE with `dmu_en=0` and HI/LO unchanged. `flush` in IDLE blocks acceptance.
- `stall` = RUN & (`rd_en` | `req_valid`). Independent instructions flow freely during RUN.
- `rd_data` = `rd_sel ? hi : lo`, with no bypass. Writes are visible the cycle after the edge.
- `dmu_en` is always low for at least one cycle between operations, because acceptance occurs only in IDLE. `dmu` relies on this rising edge to restart its counter.
- DIV quotient goes to LO and remainder to HI. This mapping is performed inside `dmu`; `hilo_unit` copies `dmu_lo`/`dmu_hi` directly.

## Timing
- Reset values: state IDLE, `hi=lo=0`, `dmu_en=0`, `dmu_m=0`, `dmu_a=dmu_b=0`, `cnt=0`. `req_ready=1`, `stall=0`.
- Reset is asynchronous. Asserting `rstn` mid-RUN immediately forces all reset values and discards the in-flight op.
- MUL accepted at edge E0: `dmu_en` is high for cycles E0..E0+MUL_LAT, and HI/LO update at edge E0+MUL_LAT. DIV is identical with DIV_LAT.
- MTHI/MTLO: 1-cycle latency.
- MFHI after MULT at E0: `stall` is high through the cycle before E0+MUL_LAT. The read returns the new value in the following cycle.

## Configuration
- `HILO_DIVZERO_CHK_EN`
  - Defined: DIV/DIVU with `req_b==0` is accepted but never enters RUN. No `dmu_en` pulse occurs, HI/LO are unchanged, and the FSM stays IDLE, so the op completes in 1 cycle.
  - Undefined: divide-by-zero runs the full DIV_LAT sequence and captures whatever `dmu` returns.

## Test plan
The bench uses a behavioural `dmu` model with the configured latencies.
- MULT, a=0xFFFFFFFD, b=7 -> `dmu_m`=0000. After 5 RUN cycles, `hi`=0xFFFFFFFF and `lo`=0xFFFFFFEB. An `rd_en` during RUN raises `stall`.
- DIVU, a=100, b=7 -> `dmu_a`=7, `dmu_b`=100, `dmu_m`=1001. At E0+36, `lo`=14 and `hi`=2.
- MTHI 0xDEADBEEF, then MFHI with `rd_sel=1` next cycle -> `rd_data`=0xDEADBEEF and `lo` unchanged.
- MULT followed by `flush` in RUN cycle 3 -> IDLE on the next edge, `dmu_en`=0, HI/LO keep prior values. A subsequent MULTU shows `dmu_en` low for at least 1 cycle before rising.
- DIV with b=0 -> with the macro: completes in 1 cycle, no `dmu_en`, HI/LO unchanged. Without the macro: 36 RUN cycles.
- `rstn` low in RUN cycle 10 of DIV -> all outputs take reset values asynchronously, and `req_ready`=1 after release.
